// File: rtl/align_shift_seq_if.sv
// Request/result handshake bundle for the iterative alignment shifter.
// The master drives requests and accepts results; the slave is the shifter.
interface align_shift_seq_if #(
    parameter int WIDTH = 24,
    parameter int AMT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sticky;

    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, out_sticky
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data, out_sticky
    );
endinterface

// File: rtl/align_shift_seq.sv
// Iterative mantissa alignment/normalisation shifter: up to 7 positions per cycle
// through one narrow mux stage, with a sticky bit accumulated on right shifts.
module align_shift_seq #(
    parameter int WIDTH = 24,
    parameter int AMT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    align_shift_seq_if.slave    bus,
    output logic [3:0]          mux_sel,
    output logic                busy
);
    localparam int RW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] data_r, data_nxt_s;
    logic             sticky_r, sticky_nxt_s;
    logic             dir_r, dir_nxt_s;
    logic [RW-1:0]    rem_r, rem_nxt_s;
    logic [RW-1:0]    amt_clamp_s;
    logic [2:0]       step_s;
    logic [WIDTH-1:0] lost_s;

    logic             in_ready_r, out_valid_r, busy_r;
    logic [3:0]       mux_sel_r;
    logic             in_ready_nxt_s, out_valid_nxt_s, busy_nxt_s;
    logic [3:0]       mux_sel_nxt_s;

    // One stage reaches at most 7 positions; the remainder is carried to later cycles.
    function automatic logic [2:0] step_of(input logic [RW-1:0] rem);
        if (rem > RW'(3'd7)) begin
            return 3'd7;
        end else begin
            return rem[2:0];
        end
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: working mantissa, sticky, direction and remaining amount
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r   <= '0;
            sticky_r <= 1'b0;
            dir_r    <= 1'b0;
            rem_r    <= '0;
        end else begin
            data_r   <= data_nxt_s;
            sticky_r <= sticky_nxt_s;
            dir_r    <= dir_nxt_s;
            rem_r    <= rem_nxt_s;
        end
    end

    // Next-state and datapath update; flush overrides everything else
    always_comb begin
        state_nxt_s  = state_r;
        data_nxt_s   = data_r;
        sticky_nxt_s = sticky_r;
        dir_nxt_s    = dir_r;
        rem_nxt_s    = rem_r;
        step_s       = step_of(rem_r);
        lost_s       = data_r & ~({WIDTH{1'b1}} << step_s);
        // Anything at or beyond the mantissa width shifts every bit out.
        if (bus.in_amt >= AMT_W'(WIDTH)) begin
            amt_clamp_s = RW'(WIDTH);
        end else begin
            amt_clamp_s = RW'(bus.in_amt);
        end

        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        data_nxt_s   = bus.in_data;
                        dir_nxt_s    = bus.in_dir;
                        sticky_nxt_s = 1'b0;
                        rem_nxt_s    = amt_clamp_s;
                        if (amt_clamp_s == '0) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_SHIFT;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (dir_r) begin
                        data_nxt_s = data_r << step_s;
                    end else begin
                        data_nxt_s   = data_r >> step_s;
                        sticky_nxt_s = sticky_r | (|lost_s);
                    end
                    rem_nxt_s = rem_r - RW'(step_s);
                    if (rem_nxt_s == '0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode of the upcoming state, so the flops below present it in that state
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        mux_sel_nxt_s   = 4'b0000;
        case (state_nxt_s)
            ST_IDLE: begin
                in_ready_nxt_s = 1'b1;
            end
            ST_SHIFT: begin
                busy_nxt_s    = 1'b1;
                mux_sel_nxt_s = {dir_nxt_s, step_of(rem_nxt_s)};
            end
            ST_DONE: begin
                busy_nxt_s      = 1'b1;
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; in_ready reflects the IDLE state held by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            mux_sel_r   <= 4'b0000;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            mux_sel_r   <= mux_sel_nxt_s;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = data_r;
    assign bus.out_sticky = sticky_r;
    assign mux_sel        = mux_sel_r;
    assign busy           = busy_r;
endmodule

// File: tb/tb_align_shift_seq.sv
// Directed-vector bench for align_shift_seq: latency, mux_sel sequence, result,
// clamping, back-pressure, back-to-back, async reset and flush.
module tb_align_shift_seq;
    localparam int WIDTH = 24;
    localparam int AMT_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] mux_sel;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    align_shift_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus_if ();

    align_shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .bus     (bus_if),
        .mux_sel (mux_sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Present a request for one cycle, then collect mux_sel per cycle until out_valid.
    // lat counts cycles from the accepting edge; 0 means the 40-cycle budget expired.
    task automatic run_op(input logic [23:0] d, input logic [7:0] a, input logic dir,
                          output int lat, output logic [31:0] sels);
        bus_if.in_data  = d;
        bus_if.in_amt   = a;
        bus_if.in_dir   = dir;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat  = 0;
        sels = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            if (bus_if.out_valid === 1'b1) begin
                lat = k;
                break;
            end
            sels = {sels[27:0], mux_sel};
            @(posedge clk); #1;
        end
    endtask

    task automatic handshake();
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({bus_if.out_valid, bus_if.out_sticky, bus_if.out_data, mux_sel, busy} !== {1'b0, 1'b0, 24'h0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b s=%b d=%h sel=%h busy=%b want all 0",
                     bus_if.out_valid, bus_if.out_sticky, bus_if.out_data, mux_sel, busy);
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({bus_if.in_ready, busy, bus_if.out_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_release got in_ready=%b busy=%b out_valid=%b want 1,0,0",
                     bus_if.in_ready, busy, bus_if.out_valid);
        end
    endtask

    task automatic test_right_align();
        int lat;
        logic [31:0] sels;
        run_op(24'h800001, 8'd10, 1'b0, lat, sels);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL right_latency got %0d want 3", lat); end
        vectors++;
        if (sels !== 32'h00000073) begin miscompares++; $display("FAIL right_mux_sel got %h want 00000073", sels); end
        vectors++;
        if ({bus_if.out_data, bus_if.out_sticky} !== {24'h002000, 1'b1}) begin
            miscompares++;
            $display("FAIL right_result got %h/%b want 002000/1", bus_if.out_data, bus_if.out_sticky);
        end
        vectors++;
        if ({bus_if.in_ready, busy, mux_sel} !== {1'b0, 1'b1, 4'h0}) begin
            miscompares++;
            $display("FAIL right_done_flags got in_ready=%b busy=%b sel=%h want 0,1,0", bus_if.in_ready, busy, mux_sel);
        end
        handshake();
        vectors++;
        if ({bus_if.in_ready, bus_if.out_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL right_after_hs got in_ready=%b out_valid=%b busy=%b want 1,0,0",
                     bus_if.in_ready, bus_if.out_valid, busy);
        end
    endtask

    task automatic test_left_norm();
        int lat;
        logic [31:0] sels;
        run_op(24'h000001, 8'd23, 1'b1, lat, sels);
        vectors++;
        if (lat !== 5) begin miscompares++; $display("FAIL left_latency got %0d want 5", lat); end
        vectors++;
        if (sels !== 32'h0000FFFA) begin miscompares++; $display("FAIL left_mux_sel got %h want 0000fffa", sels); end
        vectors++;
        if ({bus_if.out_data, bus_if.out_sticky} !== {24'h800000, 1'b0}) begin
            miscompares++;
            $display("FAIL left_result got %h/%b want 800000/0", bus_if.out_data, bus_if.out_sticky);
        end
        handshake();
    endtask

    task automatic test_zero_amt();
        int lat;
        logic [31:0] sels;
        run_op(24'hABCDEF, 8'd0, 1'b0, lat, sels);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL zero_latency got %0d want 1", lat); end
        vectors++;
        if ({sels, mux_sel} !== 36'h0) begin miscompares++; $display("FAIL zero_mux_sel got %h/%h want 0", sels, mux_sel); end
        vectors++;
        if ({bus_if.out_data, bus_if.out_sticky} !== {24'hABCDEF, 1'b0}) begin
            miscompares++;
            $display("FAIL zero_result got %h/%b want abcdef/0", bus_if.out_data, bus_if.out_sticky);
        end
        handshake();
    endtask

    task automatic test_clamp();
        int lat;
        logic [31:0] sels;
        run_op(24'h000003, 8'd200, 1'b0, lat, sels);
        vectors++;
        if (lat !== 5) begin miscompares++; $display("FAIL clamp_r_latency got %0d want 5", lat); end
        vectors++;
        if (sels !== 32'h00007773) begin miscompares++; $display("FAIL clamp_r_mux_sel got %h want 00007773", sels); end
        vectors++;
        if ({bus_if.out_data, bus_if.out_sticky} !== {24'h000000, 1'b1}) begin
            miscompares++;
            $display("FAIL clamp_r_result got %h/%b want 000000/1", bus_if.out_data, bus_if.out_sticky);
        end
        handshake();
        run_op(24'hFFFFFF, 8'd24, 1'b1, lat, sels);
        vectors++;
        if (sels !== 32'h0000FFFB) begin miscompares++; $display("FAIL clamp_l_mux_sel got %h want 0000fffb", sels); end
        vectors++;
        if ({bus_if.out_data, bus_if.out_sticky} !== {24'h000000, 1'b0}) begin
            miscompares++;
            $display("FAIL clamp_l_result got %h/%b want 000000/0", bus_if.out_data, bus_if.out_sticky);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] sels;
        run_op(24'h123456, 8'd4, 1'b0, lat, sels);
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL bp_latency got %0d want 2", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({bus_if.out_valid, bus_if.in_ready, bus_if.out_sticky, bus_if.out_data} !== {1'b1, 1'b0, 1'b1, 24'h012345}) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got v=%b rdy=%b s=%b d=%h want 1,0,1,012345",
                         c, bus_if.out_valid, bus_if.in_ready, bus_if.out_sticky, bus_if.out_data);
            end
        end
        handshake();
        vectors++;
        if ({bus_if.in_ready, bus_if.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_ready_after_hs got in_ready=%b out_valid=%b want 1,0", bus_if.in_ready, bus_if.out_valid);
        end
        run_op(24'h000F00, 8'd8, 1'b1, lat, sels);
        vectors++;
        if ({lat[3:0], sels, bus_if.out_data, bus_if.out_sticky} !== {4'd3, 32'h000000F9, 24'h0F0000, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_op1 got lat=%0d sel=%h d=%h s=%b want 3,000000f9,0f0000,0",
                     lat, sels, bus_if.out_data, bus_if.out_sticky);
        end
        handshake();
        run_op(24'h00000F, 8'd3, 1'b0, lat, sels);
        vectors++;
        if ({lat[3:0], sels, bus_if.out_data, bus_if.out_sticky} !== {4'd2, 32'h00000003, 24'h000001, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_op2 got lat=%0d sel=%h d=%h s=%b want 2,00000003,000001,1",
                     lat, sels, bus_if.out_data, bus_if.out_sticky);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] sels;
        bus_if.in_data  = 24'hFFFFFF;
        bus_if.in_amt   = 8'd20;
        bus_if.in_dir   = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, mux_sel} !== {1'b1, 4'h7}) begin
            miscompares++;
            $display("FAIL rstmid_shift2 got busy=%b sel=%h want 1,7", busy, mux_sel);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus_if.out_valid, bus_if.out_sticky, bus_if.out_data, mux_sel, busy} !== {1'b0, 1'b0, 24'h0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL rstmid_immediate got v=%b s=%b d=%h sel=%h busy=%b want all 0",
                     bus_if.out_valid, bus_if.out_sticky, bus_if.out_data, mux_sel, busy);
        end
        #2 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({bus_if.in_ready, bus_if.out_valid, busy} !== 3'b100) begin
                miscompares++;
                $display("FAIL rstmid_idle cycle %0d got in_ready=%b out_valid=%b busy=%b want 1,0,0",
                         c, bus_if.in_ready, bus_if.out_valid, busy);
            end
        end
        run_op(24'h0000FF, 8'd7, 1'b0, lat, sels);
        vectors++;
        if ({lat[3:0], sels, bus_if.out_data, bus_if.out_sticky} !== {4'd2, 32'h00000007, 24'h000001, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_recover got lat=%0d sel=%h d=%h s=%b want 2,00000007,000001,1",
                     lat, sels, bus_if.out_data, bus_if.out_sticky);
        end
        handshake();
    endtask

    task automatic test_flush();
        int lat;
        logic [31:0] sels;
        bus_if.in_data  = 24'h000001;
        bus_if.in_amt   = 8'd20;
        bus_if.in_dir   = 1'b1;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if ({bus_if.out_valid, mux_sel, busy, bus_if.in_ready} !== {1'b0, 4'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_shift got v=%b sel=%h busy=%b rdy=%b want 0,0,0,1",
                     bus_if.out_valid, mux_sel, busy, bus_if.in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({bus_if.out_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL flush_no_result cycle %0d got out_valid=%b busy=%b want 0,0", c, bus_if.out_valid, busy);
            end
        end
        run_op(24'h000055, 8'd0, 1'b0, lat, sels);
        flush = 1'b1;
        bus_if.out_ready = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if ({lat[3:0], bus_if.out_valid, bus_if.in_ready} !== {4'd1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_done got lat=%0d out_valid=%b in_ready=%b want 1,0,1", lat, bus_if.out_valid, bus_if.in_ready);
        end
        bus_if.in_data  = 24'h000055;
        bus_if.in_amt   = 8'd3;
        bus_if.in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        flush = 1'b0;
        vectors++;
        if ({busy, mux_sel, bus_if.in_ready} !== {1'b0, 4'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_over_valid got busy=%b sel=%h in_ready=%b want 0,0,1", busy, mux_sel, bus_if.in_ready);
        end
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 24'h0;
        bus_if.in_amt    = 8'h0;
        bus_if.in_dir    = 1'b0;
        bus_if.out_ready = 1'b0;
        test_reset();
        test_right_align();
        test_left_norm();
        test_zero_amt();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
